// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM operand info in, stall/flush controls out.
// The pipeline side uses the master modport and hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic             IFID_usert;
  logic [2:0]       IFID_pcsrc;
  logic             br_taken;
  logic             IDEX_memrd;
  logic             IDEX_regwr;
  logic [4:0]       IDEX_rd;
  logic             IDEX_mdstart;
  logic             EXMEM_memrd;
  logic [4:0]       EXMEM_rd;
  logic             pc_wr;
  logic             IFID_wr;
  logic             IFID_flush;
  logic             IDEX_wr;
  logic             IDEX_flush;
  logic             EXMEM_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output IFID_rs, IFID_rt, IFID_usert, IFID_pcsrc, br_taken,
    output IDEX_memrd, IDEX_regwr, IDEX_rd, IDEX_mdstart,
    output EXMEM_memrd, EXMEM_rd,
    input  pc_wr, IFID_wr, IFID_flush, IDEX_wr, IDEX_flush, EXMEM_flush,
    input  md_busy, stall_cnt
  );

  modport slave (
    input  IFID_rs, IFID_rt, IFID_usert, IFID_pcsrc, br_taken,
    input  IDEX_memrd, IDEX_regwr, IDEX_rd, IDEX_mdstart,
    input  EXMEM_memrd, EXMEM_rd,
    output pc_wr, IFID_wr, IFID_flush, IDEX_wr, IDEX_flush, EXMEM_flush,
    output md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS core: load-use and branch-operand
// bubbles, mul/div EX occupancy, control-transfer flushes and a stall counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t           state_r;
  logic [3:0]       md_left_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic ctl_s, taken_s, src_ex_s, cmp_ex_s, cmp_mem_s, lu_s, bh_s, stall_s;
  logic pc_wr_s, IFID_wr_s, IFID_flush_s, IDEX_wr_s, IDEX_flush_s, EXMEM_flush_s, md_busy_s;

  // Decode the ID control-transfer type; unknown encodings fall to sequential.
  always_comb begin
    ctl_s   = 1'b0;
    taken_s = 1'b0;
    case (hz.IFID_pcsrc)
      3'b001: begin
        ctl_s   = 1'b1;
        taken_s = hz.br_taken;
      end
      3'b011: begin
        ctl_s   = 1'b1;
        taken_s = 1'b1;
      end
      3'b010: begin
        ctl_s   = 1'b0;
        taken_s = 1'b1;
      end
      default: begin
        ctl_s   = 1'b0;
        taken_s = 1'b0;
      end
    endcase
  end

  assign src_ex_s  = (hz.IDEX_rd != 5'd0) &&
                     ((hz.IDEX_rd == hz.IFID_rs) || (hz.IFID_usert && (hz.IDEX_rd == hz.IFID_rt)));
  assign cmp_ex_s  = (hz.IDEX_rd != 5'd0) &&
                     ((hz.IDEX_rd == hz.IFID_rs) || (hz.IDEX_rd == hz.IFID_rt));
  assign cmp_mem_s = (hz.EXMEM_rd != 5'd0) &&
                     ((hz.EXMEM_rd == hz.IFID_rs) || (hz.EXMEM_rd == hz.IFID_rt));
  assign lu_s      = hz.IDEX_memrd && src_ex_s;
  assign bh_s      = ctl_s && ((hz.IDEX_regwr && cmp_ex_s) || (hz.EXMEM_memrd && cmp_mem_s));
  assign stall_s   = lu_s || bh_s;

  // Pipeline enables/flushes; mul/div occupancy outranks hazards, hazards outrank flushes.
  always_comb begin
    pc_wr_s       = 1'b1;
    IFID_wr_s     = 1'b1;
    IFID_flush_s  = 1'b0;
    IDEX_wr_s     = 1'b1;
    IDEX_flush_s  = 1'b0;
    EXMEM_flush_s = 1'b0;
    md_busy_s     = 1'b0;
    if (reset) begin
      md_busy_s = 1'b0;
    end else if ((state_r == MD_WAIT) || hz.IDEX_mdstart) begin
      pc_wr_s       = 1'b0;
      IFID_wr_s     = 1'b0;
      IDEX_wr_s     = 1'b0;
      EXMEM_flush_s = 1'b1;
      md_busy_s     = 1'b1;
    end else if (stall_s) begin
      pc_wr_s      = 1'b0;
      IFID_wr_s    = 1'b0;
      IDEX_flush_s = 1'b1;
    end else if (taken_s) begin
      IFID_flush_s = 1'b1;
    end else begin
      IFID_flush_s = 1'b0;
    end
  end

  // FSM, mul/div countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      md_left_r   <= 4'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_wr_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      case (state_r)
        RUN: begin
          if (hz.IDEX_mdstart) begin
            state_r   <= MD_WAIT;
            md_left_r <= 4'(MD_LAT - 1);
          end else begin
            state_r   <= RUN;
            md_left_r <= 4'd0;
          end
        end
        MD_WAIT: begin
          // <= 1 rather than == 1 so a corrupted zero count cannot trap the FSM.
          if (md_left_r <= 4'd1) begin
            state_r   <= RUN;
            md_left_r <= 4'd0;
          end else begin
            state_r   <= MD_WAIT;
            md_left_r <= md_left_r - 4'd1;
          end
        end
        default: begin
          state_r   <= RUN;
          md_left_r <= 4'd0;
        end
      endcase
    end
  end

  assign hz.pc_wr       = pc_wr_s;
  assign hz.IFID_wr     = IFID_wr_s;
  assign hz.IFID_flush  = IFID_flush_s;
  assign hz.IDEX_wr     = IDEX_wr_s;
  assign hz.IDEX_flush  = IDEX_flush_s;
  assign hz.EXMEM_flush = EXMEM_flush_s;
  assign hz.md_busy     = md_busy_s;
  assign hz.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_vec = 0;
  int n_err = 0;
  int busy_rem = 0;   // EX cycles still owed to an in-flight mul/div after this one
  int cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_in(input int rs, input int rt, input int usert, input int pcsrc, input int tk,
                        input int memrd, input int regwr, input int rd, input int md,
                        input int m_memrd, input int m_rd);
    hz.IFID_rs      = 5'(rs);
    hz.IFID_rt      = 5'(rt);
    hz.IFID_usert   = 1'(usert);
    hz.IFID_pcsrc   = 3'(pcsrc);
    hz.br_taken     = 1'(tk);
    hz.IDEX_memrd   = 1'(memrd);
    hz.IDEX_regwr   = 1'(regwr);
    hz.IDEX_rd      = 5'(rd);
    hz.IDEX_mdstart = 1'(md);
    hz.EXMEM_memrd  = 1'(m_memrd);
    hz.EXMEM_rd     = 5'(m_rd);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    int rs, rt, dex, dmem, pcs;
    bit lu, bh, ctl, taken, busy, stall;
    bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exf, e_busy;
    @(negedge clk);
    rs = hz.IFID_rs; rt = hz.IFID_rt; dex = hz.IDEX_rd; dmem = hz.EXMEM_rd; pcs = hz.IFID_pcsrc;
    ctl   = (pcs == 1) || (pcs == 3);
    taken = (pcs == 1 && hz.br_taken) || pcs == 2 || pcs == 3;
    lu = hz.IDEX_memrd && dex != 0 && (dex == rs || (hz.IFID_usert && dex == rt));
    bh = ctl && ((hz.IDEX_regwr && dex != 0 && (dex == rs || dex == rt)) ||
                 (hz.EXMEM_memrd && dmem != 0 && (dmem == rs || dmem == rt)));
    stall = lu || bh;
    busy  = !reset && (busy_rem > 0 || hz.IDEX_mdstart);
    e_pc   = !(busy || (!reset && stall));
    e_ifw  = e_pc;
    e_idw  = !busy;
    e_idf  = !reset && !busy && stall;
    e_exf  = busy;
    e_busy = busy;
    e_iff  = !reset && !busy && !stall && taken;
    check("pc_wr",       hz.pc_wr,       32'(e_pc));
    check("IFID_wr",     hz.IFID_wr,     32'(e_ifw));
    check("IFID_flush",  hz.IFID_flush,  32'(e_iff));
    check("IDEX_wr",     hz.IDEX_wr,     32'(e_idw));
    check("IDEX_flush",  hz.IDEX_flush,  32'(e_idf));
    check("EXMEM_flush", hz.EXMEM_flush, 32'(e_exf));
    check("md_busy",     hz.md_busy,     32'(e_busy));
    check("stall_cnt",   hz.stall_cnt,   32'(cnt_m));
    @(posedge clk);
    if (reset) begin
      busy_rem = 0;
      cnt_m    = 0;
    end else begin
      if (!e_pc && cnt_m < CNT_MAX) cnt_m++;
      if (busy_rem > 0) busy_rem--;
      else if (hz.IDEX_mdstart) busy_rem = MD_LAT - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    reset = 1'b0;

    // load-use on rs, then the load leaves EX
    set_in(5, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0); cycle();
    set_in(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5); cycle();
    check("lu_cnt", hz.stall_cnt, 32'd1);
    // zero register and unused rt
    set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
    set_in(1, 7, 0, 0, 0, 1, 1, 7, 0, 0, 0); cycle();
    check("no_stall_cnt", hz.stall_cnt, 32'd1);

    // branch after load (2 stalls) then branch after ALU op (1 stall)
    do_reset();
    set_in(3, 4, 1, 1, 0, 1, 1, 3, 0, 0, 0); cycle();
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3); cycle();
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(3, 4, 1, 1, 0, 0, 1, 3, 0, 0, 0); cycle();
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 3); cycle();
    check("br_cnt", hz.stall_cnt, 32'd3);

    // taken branch clean, then with a pending hazard, then jr and j
    set_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
    set_in(1, 2, 1, 1, 1, 0, 1, 2, 0, 0, 0); cycle();
    set_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
    set_in(9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0); cycle();

    // mul/div with a concurrent load-use hazard
    do_reset();
    set_in(5, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0); cycle();
    set_in(5, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("md_cnt", hz.stall_cnt, 32'd4);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // reset while in MD_WAIT
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    check("rst_busy", hz.md_busy, 32'd0);
    check("rst_cnt",  hz.stall_cnt, 32'd0);

    // counter saturation
    set_in(5, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle();
    check("sat_cnt", hz.stall_cnt, 32'(CNT_MAX));
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 19) == 0),
             $urandom_range(0, 1), $urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
